io_bus_master: RTL and testbench
================================

Name: io_bus_master

Overview:
- CPU-side initiator for the memory-mapped IO bus; the IO peripheral block is the responder on the other end.
- Accepts one load, store or poll request at a time from the CPU pipeline and drives io_addr/io_data/io_write.
- Waits out the peripheral's registered read latency, then captures io_rdata.
- Optionally re-reads an address until masked bits match a value (button/switch wait) or a retry limit expires.

Parameters:
- ADDR_W, 16, IO address width.
- DATA_W, 16, IO data width.
- READ_LATENCY, 1, cycles from io_addr valid to io_rdata valid. Minimum 1.
- POLL_W, 16, width of the poll retry counter and poll_limit.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  CPU request strobe.
- req_ready  out  1  high only in IDLE; a request is accepted on req_valid && req_ready.
- req_write  in  1  1=store, 0=load/poll.
- req_poll  in  1  load repeats until match or limit.
- req_addr  in  ADDR_W  target address.
- req_wdata  in  DATA_W  store data.
- req_mask  in  DATA_W  poll compare mask.
- req_match  in  DATA_W  poll compare value.
- poll_limit  in  POLL_W  number of extra reads allowed after the first.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  DATA_W  read data (last sample for poll; 0 for store).
- rsp_timeout  out  1  poll ended without a match; valid with rsp_valid.
- io_addr  out  ADDR_W  registered address to the peripheral.
- io_data  out  DATA_W  registered write data.
- io_write  out  1  write strobe.
- io_rdata  in  DATA_W  peripheral registered read data.

Behaviour:
- Reset values: state IDLE; req_ready=1; rsp_valid=0; rsp_rdata=0; rsp_timeout=0; io_addr=0; io_data=0; io_write=0; counters 0.
- Reset mid-operation: abandon the transaction at the next edge and issue no response. Reset has priority over everything.
- States: IDLE, WRITE, READ_WAIT, RESP.
- IDLE (cycle 0 = accept cycle):
  - Latch req_addr into io_addr, req_wdata into io_data.
  - Latch mask, match and poll_limit.
  - If req_write, go to WRITE; otherwise load the latency counter and go to READ_WAIT.
  - When req_write=1, req_poll is ignored.
- WRITE (cycle 1): io_write=1 for exactly this cycle, then go to RESP.
- RESP (cycle 2):
  - rsp_valid=1 for exactly one cycle; rsp_rdata=0 and rsp_timeout=0 for a store.
  - Next cycle returns to IDLE.
- READ_WAIT:
  - Occupies READ_LATENCY+1 cycles. io_rdata is sampled on the edge ending the last of these cycles.
  - Plain load: rsp_rdata <= io_rdata, then go to RESP. With READ_LATENCY=1, rsp_valid is high in cycle 3.
  - Poll, match when (io_rdata & mask) == (match & mask): RESP with timeout=0.
  - Poll, no match and attempt count == poll_limit: RESP with rsp_timeout=1 and the last sample.
  - Poll, otherwise: increment the attempt count and re-enter READ_WAIT for another READ_LATENCY+1 cycles.
  - poll_limit=0 means a single read. Maximum reads = poll_limit+1.
- req_ready=0 in every state except IDLE. req_valid while busy is ignored; the CPU must hold its request.
- io_addr and io_data hold their last values while IDLE.
- io_write=0 in every state except WRITE, so idle bus reads are harmless.
- rsp_rdata and rsp_timeout hold until the next response.
- Attempt counter is POLL_W wide and compared for equality; it cannot wrap because it stops at poll_limit.

Test Plan:
- Store: addr 0x0000, wdata 0x00A5, write=1 -> io_write=1 only in cycle 1 with io_addr=0x0000, io_data=0x00A5; rsp_valid in cycle 2, rsp_timeout=0; req_ready=1 in cycle 3.
- Load: peripheral model registers {switches,12'b0} for addr 1, switches=4'b1010 -> rsp_valid in cycle 3, rsp_rdata=0xA000, io_write never high.
- Poll hit: addr 0, mask=0x8000, match=0x8000, poll_limit=100, button raised at cycle 20 -> rsp_rdata=0x8000, rsp_timeout=0, rsp_valid exactly once within 2 cycles after the first matching sample.
- Poll timeout: poll_limit=3, button held 0 -> samples at the ends of cycles 2/4/6/8; rsp_valid in cycle 9 with rsp_timeout=1, rsp_rdata=0x0000.
- Reset mid-poll: rst high in cycle 5 of a poll -> next cycle req_ready=1, io_addr=0, io_write=0, rsp_valid=0, and no later response.
- Priority/busy: req_write=1 with req_poll=1 -> behaves as a store. A second req_valid pulse during WRITE is dropped (no second io_write).

Source files
------------

// File: rtl/io_bus_master.sv
// io_bus_master: CPU-side initiator for the memory-mapped IO bus.
// Takes one load / store / poll request at a time, drives the registered
// io_addr/io_data/io_write signals, waits out the peripheral read latency
// and returns a single-cycle completion pulse with the captured read data.
module io_bus_master #(
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 16,
    parameter int READ_LATENCY = 1,
    parameter int POLL_W       = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic              req_poll,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [DATA_W-1:0] req_mask,
    input  logic [DATA_W-1:0] req_match,
    input  logic [POLL_W-1:0] poll_limit,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_timeout,
    output logic [ADDR_W-1:0] io_addr,
    output logic [DATA_W-1:0] io_data,
    output logic              io_write,
    input  logic [DATA_W-1:0] io_rdata
);

    // The wait counter counts down from READ_LATENCY to 0, so a READ_WAIT
    // pass lasts READ_LATENCY+1 cycles and samples io_rdata when it hits 0.
    localparam int              LAT_W    = $clog2(READ_LATENCY + 1);
    localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(READ_LATENCY);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WRITE     = 2'd1,
        S_READ_WAIT = 2'd2,
        S_RESP      = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_next;

    logic [ADDR_W-1:0]  r_io_addr;
    logic [DATA_W-1:0]  r_io_data;
    logic [DATA_W-1:0]  r_mask;
    logic [DATA_W-1:0]  r_match;
    logic [POLL_W-1:0]  r_limit;
    logic [POLL_W-1:0]  r_attempt;
    logic [LAT_W-1:0]   r_lat_cnt;
    logic               r_poll;
    logic [DATA_W-1:0]  r_rsp_rdata;
    logic               r_rsp_timeout;

    logic               w_accept;
    logic               w_sample;
    logic               w_hit;
    logic               w_read_done;

    assign w_accept    = req_valid && (r_state == S_IDLE);
    assign w_sample    = (r_state == S_READ_WAIT) && (r_lat_cnt == '0);
    // Only bits selected by the mask take part in the poll comparison.
    assign w_hit       = ((io_rdata ^ r_match) & r_mask) == '0;
    // A read pass ends the transaction for a plain load, on a poll match,
    // or when the poll has used up its extra reads.
    assign w_read_done = w_sample && (!r_poll || w_hit || (r_attempt == r_limit));

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_next = req_write ? S_WRITE : S_READ_WAIT;
                end
            end
            S_WRITE: begin
                w_state_next = S_RESP;
            end
            S_READ_WAIT: begin
                if (w_read_done) begin
                    w_state_next = S_RESP;
                end
            end
            S_RESP: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Request capture, latency/attempt counters and response registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_io_addr     <= '0;
            r_io_data     <= '0;
            r_mask        <= '0;
            r_match       <= '0;
            r_limit       <= '0;
            r_attempt     <= '0;
            r_lat_cnt     <= '0;
            r_poll        <= 1'b0;
            r_rsp_rdata   <= '0;
            r_rsp_timeout <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_io_addr <= req_addr;
                        r_io_data <= req_wdata;
                        r_mask    <= req_mask;
                        r_match   <= req_match;
                        r_limit   <= poll_limit;
                        // A store never polls, whatever req_poll says.
                        r_poll    <= req_poll && !req_write;
                        r_attempt <= '0;
                        r_lat_cnt <= LAT_LOAD;
                    end
                end
                S_WRITE: begin
                    r_rsp_rdata   <= '0;
                    r_rsp_timeout <= 1'b0;
                end
                S_READ_WAIT: begin
                    if (r_lat_cnt != '0) begin
                        r_lat_cnt <= r_lat_cnt - 1'b1;
                    end else if (w_read_done) begin
                        r_rsp_rdata   <= io_rdata;
                        r_rsp_timeout <= r_poll && !w_hit;
                    end else begin
                        r_attempt <= r_attempt + 1'b1;
                        r_lat_cnt <= LAT_LOAD;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign req_ready   = (r_state == S_IDLE);
    assign rsp_valid   = (r_state == S_RESP);
    assign rsp_rdata   = r_rsp_rdata;
    assign rsp_timeout = r_rsp_timeout;
    assign io_addr     = r_io_addr;
    assign io_data     = r_io_data;
    // The strobe comes straight from the state register, so it is glitch-free
    // and high only during the single WRITE cycle.
    assign io_write    = (r_state == S_WRITE);

endmodule

// File: tb/tb_io_bus_master.sv
// tb_io_bus_master: directed bench for io_bus_master with a small
// registered-read peripheral (button at addr 0, switches at addr 1).
module tb_io_bus_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic        req_poll;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic [15:0] req_mask;
    logic [15:0] req_match;
    logic [15:0] poll_limit;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        rsp_timeout;
    logic [15:0] io_addr;
    logic [15:0] io_data;
    logic        io_write;
    logic [15:0] io_rdata = 16'h0;

    logic        button   = 1'b0;
    logic [3:0]  switches = 4'b0000;

    int total = 0;
    int bad   = 0;
    int wr_cnt  = 0;
    int rsp_cnt = 0;

    io_bus_master #(
        .ADDR_W(16), .DATA_W(16), .READ_LATENCY(1), .POLL_W(16)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_poll(req_poll),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .req_mask(req_mask), .req_match(req_match),
        .poll_limit(poll_limit),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_timeout(rsp_timeout),
        .io_addr(io_addr), .io_data(io_data), .io_write(io_write),
        .io_rdata(io_rdata)
    );

    always #5 clk = ~clk;

    // Peripheral with one cycle of registered read latency.
    always @(posedge clk) begin
        case (io_addr)
            16'h0000: io_rdata <= {button, 15'b0};
            16'h0001: io_rdata <= {switches, 12'b0};
            default:  io_rdata <= 16'h0000;
        endcase
    end

    // Count strobe cycles and completion pulses seen on the bus.
    always @(posedge clk) begin
        if (io_write)  wr_cnt  <= wr_cnt + 1;
        if (rsp_valid) rsp_cnt <= rsp_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present a request in the current (idle) cycle; returns in cycle 1.
    task automatic issue(input logic wr, input logic pl, input logic [15:0] a,
                         input logic [15:0] wd, input logic [15:0] m,
                         input logic [15:0] mt, input logic [15:0] lim);
        req_write  = wr;
        req_poll   = pl;
        req_addr   = a;
        req_wdata  = wd;
        req_mask   = m;
        req_match  = mt;
        poll_limit = lim;
        req_valid  = 1'b1;
        tick();
        req_valid  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int wr0;
        int rsp0;
        int hit_cycle;

        rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_poll = 1'b0;
        req_addr = '0; req_wdata = '0; req_mask = '0; req_match = '0; poll_limit = '0;
        tick(); tick(); tick();

        // Reset state.
        check("rst_ready",   32'(req_ready),   32'h1);
        check("rst_rspv",    32'(rsp_valid),   32'h0);
        check("rst_rdata",   32'(rsp_rdata),   32'h0);
        check("rst_timeout", 32'(rsp_timeout), 32'h0);
        check("rst_ioaddr",  32'(io_addr),     32'h0);
        check("rst_iodata",  32'(io_data),     32'h0);
        check("rst_iowrite", 32'(io_write),    32'h0);
        rst = 1'b0;
        tick();

        // Store 0x00A5 to address 0.
        wr0 = wr_cnt; rsp0 = rsp_cnt;
        check("st_ready_c0", 32'(req_ready), 32'h1);
        issue(1'b1, 1'b0, 16'h0000, 16'h00A5, 16'h0, 16'h0, 16'h0);
        check("st_iowrite_c1", 32'(io_write), 32'h1);
        check("st_ioaddr_c1",  32'(io_addr),  32'h0000);
        check("st_iodata_c1",  32'(io_data),  32'h00A5);
        check("st_ready_c1",   32'(req_ready), 32'h0);
        tick();
        check("st_iowrite_c2", 32'(io_write),    32'h0);
        check("st_rspv_c2",    32'(rsp_valid),   32'h1);
        check("st_timeout_c2", 32'(rsp_timeout), 32'h0);
        check("st_rdata_c2",   32'(rsp_rdata),   32'h0);
        tick();
        check("st_ready_c3", 32'(req_ready), 32'h1);
        check("st_rspv_c3",  32'(rsp_valid), 32'h0);
        check("st_wrcnt",    32'(wr_cnt - wr0),   32'd1);
        check("st_rspcnt",   32'(rsp_cnt - rsp0), 32'd1);

        // Load from switches (addr 1).
        switches = 4'b1010;
        wr0 = wr_cnt; rsp0 = rsp_cnt;
        issue(1'b0, 1'b0, 16'h0001, 16'h0000, 16'h0, 16'h0, 16'h0);
        check("ld_rspv_c1", 32'(rsp_valid), 32'h0);
        tick();
        check("ld_rspv_c2", 32'(rsp_valid), 32'h0);
        tick();
        check("ld_rspv_c3",  32'(rsp_valid), 32'h1);
        check("ld_rdata_c3", 32'(rsp_rdata), 32'hA000);
        tick();
        check("ld_ready_c4", 32'(req_ready), 32'h1);
        check("ld_wrcnt",    32'(wr_cnt - wr0), 32'd0);

        // Poll timeout: limit 3, button low -> response in cycle 9.
        button = 1'b0;
        rsp0 = rsp_cnt;
        issue(1'b0, 1'b1, 16'h0000, 16'h0, 16'h8000, 16'h8000, 16'd3);
        for (int c = 1; c < 8; c++) tick();
        check("to_rspv_c8",  32'(rsp_valid), 32'h0);
        check("to_hold_c8",  32'(rsp_rdata), 32'hA000);
        check("to_rspcnt_c8", 32'(rsp_cnt - rsp0), 32'd0);
        tick();
        check("to_rspv_c9",    32'(rsp_valid),   32'h1);
        check("to_timeout_c9", 32'(rsp_timeout), 32'h1);
        check("to_rdata_c9",   32'(rsp_rdata),   32'h0000);
        tick();

        // Write with poll set behaves as a store; a busy req_valid is dropped.
        wr0 = wr_cnt; rsp0 = rsp_cnt;
        issue(1'b1, 1'b1, 16'h0003, 16'h1234, 16'hFFFF, 16'h0, 16'd5);
        check("pr_iowrite_c1", 32'(io_write), 32'h1);
        req_wdata = 16'h5555; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        check("pr_rspv_c2",    32'(rsp_valid),   32'h1);
        check("pr_timeout_c2", 32'(rsp_timeout), 32'h0);
        check("pr_rdata_c2",   32'(rsp_rdata),   32'h0);
        for (int c = 0; c < 6; c++) tick();
        check("pr_wrcnt",  32'(wr_cnt - wr0),   32'd1);
        check("pr_rspcnt", 32'(rsp_cnt - rsp0), 32'd1);
        check("pr_iodata", 32'(io_data), 32'h1234);
        check("pr_ready",  32'(req_ready), 32'h1);

        // Poll hit: button rises in cycle 20 -> match sampled end of 22, resp in 23.
        button = 1'b0;
        rsp0 = rsp_cnt;
        hit_cycle = -1;
        issue(1'b0, 1'b1, 16'h0000, 16'h0, 16'h8000, 16'h8000, 16'd100);
        for (int c = 1; c <= 60; c++) begin
            if (c == 20) button = 1'b1;
            if (rsp_valid) begin
                hit_cycle = c;
                break;
            end
            tick();
        end
        check("ph_cycle",   32'(hit_cycle),   32'd23);
        check("ph_rdata",   32'(rsp_rdata),   32'h8000);
        check("ph_timeout", 32'(rsp_timeout), 32'h0);
        tick(); tick(); tick();
        check("ph_rspcnt", 32'(rsp_cnt - rsp0), 32'd1);
        button = 1'b0;

        // Reset asserted in cycle 5 of a poll.
        rsp0 = rsp_cnt;
        issue(1'b0, 1'b1, 16'h0002, 16'h0, 16'h8000, 16'h8000, 16'd100);
        tick(); tick(); tick(); tick();
        check("rm_busy_c5", 32'(req_ready), 32'h0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rm_ready",   32'(req_ready), 32'h1);
        check("rm_ioaddr",  32'(io_addr),   32'h0);
        check("rm_iowrite", 32'(io_write),  32'h0);
        check("rm_rspv",    32'(rsp_valid), 32'h0);
        for (int c = 0; c < 20; c++) tick();
        check("rm_rspcnt", 32'(rsp_cnt - rsp0), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
